// File: rtl/mac_sequencer.sv
// Multiply-accumulate sequencer: feeds operand pairs to an external iterative multiplier
// and accumulates sign-magnitude products with saturation. Optional watchdog: MAC_TIMEOUT_EN.
module mac_sequencer #(
   parameter int N   = 32,
   parameter int Q   = 16,
   parameter int LEN = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N-1:0]             in_a,
   input  logic [N-1:0]             in_b,
   input  logic                     in_last,
   output logic                     mul_rst,
   output logic                     mul_en,
   output logic [N-1:0]             mul_a,
   output logic [N-1:0]             mul_b,
   input  logic                     mul_done,
   input  logic [N-1:0]             mul_c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_acc,
   output logic [$clog2(LEN+1)-1:0] out_count,
`ifdef MAC_TIMEOUT_EN
   output logic                     out_err,
`endif
   output logic                     out_sat
);

   localparam int CW = $clog2(LEN+1);
   localparam logic [CW-1:0] LEN_C = CW'(LEN);
   localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {IDLE, LOAD, RUN, ACC, OUT} state_t;

   state_t          state_r, state_next_s;
   logic [N-1:0]    a_r, b_r, prod_r, acc_r;
   logic            last_r, sat_r;
   logic [CW-1:0]   count_r;
   logic [N:0]      add_s;
   logic            close_s;
`ifdef MAC_TIMEOUT_EN
   localparam int WW = $clog2(4*N);
   localparam logic [WW-1:0] WD_LIMIT = WW'(4*N-1);
   logic [WW-1:0]   wd_r;
   logic            err_r;
   logic            timeout_s;
   assign timeout_s = (wd_r == WD_LIMIT);
   assign out_err   = err_r;
`endif

   // Sign-magnitude saturating add; returns {sat, sum}. Never yields -0.
   function automatic logic [N:0] sat_add(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [N-1:0] sum;
      logic         sx, sy;
      logic [N-2:0] mx, my;
      mx  = x[N-2:0];
      my  = y[N-2:0];
      sx  = x[N-1] && (mx != {(N-1){1'b0}});
      sy  = y[N-1] && (my != {(N-1){1'b0}});
      sum = {1'b0, mx} + {1'b0, my};
      if (sx == sy) begin
         if (sum[N-1]) sat_add = {1'b1, sx, {(N-1){1'b1}}};
         else          sat_add = {1'b0, sx, sum[N-2:0]};
      end else if (mx > my) begin
         sat_add = {1'b0, sx, mx - my};
      end else if (my > mx) begin
         sat_add = {1'b0, sy, my - mx};
      end else begin
         sat_add = {(N+1){1'b0}};
      end
   endfunction

   assign add_s   = sat_add(acc_r, prod_r);
   assign close_s = last_r || ((count_r + ONE_C) == LEN_C);

   assign in_ready  = (state_r == IDLE) && !rst;
   assign mul_rst   = rst || (state_r == LOAD);
   assign mul_en    = (state_r == RUN) && !rst;
   assign mul_a     = a_r;
   assign mul_b     = b_r;
   assign out_valid = (state_r == OUT);
   assign out_acc   = acc_r;
   assign out_count = count_r;
   assign out_sat   = sat_r;

   // State register and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_r     <= {N{1'b0}};
         b_r     <= {N{1'b0}};
         last_r  <= 1'b0;
         prod_r  <= {N{1'b0}};
         acc_r   <= {N{1'b0}};
         count_r <= {CW{1'b0}};
         sat_r   <= 1'b0;
`ifdef MAC_TIMEOUT_EN
         wd_r    <= {WW{1'b0}};
         err_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_next_s;
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r    <= in_a;
                  b_r    <= in_b;
                  last_r <= in_last;
               end
            end
            LOAD: begin
`ifdef MAC_TIMEOUT_EN
               wd_r <= {WW{1'b0}};
`endif
            end
            RUN: begin
               if (mul_done) begin
                  prod_r <= mul_c;
`ifdef MAC_TIMEOUT_EN
               end else if (timeout_s) begin
                  prod_r <= {N{1'b0}};
                  err_r  <= 1'b1;
`endif
               end
`ifdef MAC_TIMEOUT_EN
               wd_r <= wd_r + {{(WW-1){1'b0}}, 1'b1};
`endif
            end
            ACC: begin
               acc_r   <= add_s[N-1:0];
               sat_r   <= sat_r | add_s[N];
               count_r <= count_r + ONE_C;
            end
            OUT: begin
               if (out_ready) begin
                  acc_r   <= {N{1'b0}};
                  count_r <= {CW{1'b0}};
                  sat_r   <= 1'b0;
`ifdef MAC_TIMEOUT_EN
                  err_r   <= 1'b0;
`endif
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: if (in_valid) state_next_s = LOAD; else state_next_s = IDLE;
         LOAD: state_next_s = RUN;
         RUN: begin
            if (mul_done) state_next_s = ACC;
`ifdef MAC_TIMEOUT_EN
            else if (timeout_s) state_next_s = ACC;
`endif
            else state_next_s = RUN;
         end
         ACC:  if (close_s) state_next_s = OUT; else state_next_s = IDLE;
         OUT:  if (out_ready) state_next_s = IDLE; else state_next_s = OUT;
         default: state_next_s = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer (LEN=4) with a behavioural latency-8 multiplier.
module tb_mac_sequencer;
   localparam int N = 32;
   localparam int Q = 16;
   localparam int LEN = 4;
   localparam int LAT = 8;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_last, out_ready;
   logic [N-1:0]  in_a, in_b;
   logic          in_ready, mul_rst, mul_en, mul_done, out_valid, out_sat;
   logic [N-1:0]  mul_a, mul_b, mul_c, out_acc;
   logic [2:0]    out_count;
`ifdef MAC_TIMEOUT_EN
   logic          out_err;
`endif

   int compares = 0;
   int fails = 0;
   logic stall = 1'b0;
   int mcnt;
   logic mdone;
   logic [N-1:0] mc;

   always #5 clk = ~clk;

   mac_sequencer #(.N(N), .Q(Q), .LEN(LEN)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
      .mul_done(mul_done), .mul_c(mul_c),
      .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
      .out_count(out_count),
`ifdef MAC_TIMEOUT_EN
      .out_err(out_err),
`endif
      .out_sat(out_sat)
   );

   function automatic logic [N-1:0] mult(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [63:0] p;
      logic [N-2:0] m;
      p = {33'd0, x[N-2:0]} * {33'd0, y[N-2:0]};
      m = p[Q +: (N-1)];
      mult = {(x[N-1] ^ y[N-1]) && (m != 31'd0), m};
   endfunction

   // Behavioural iterative multiplier: done LAT enabled cycles after rst
   always @(posedge clk) begin
      if (mul_rst) begin
         mcnt  <= 0;
         mdone <= 1'b0;
         mc    <= 32'd0;
      end else if (mul_en && !mdone && !stall) begin
         if (mcnt == LAT-1) begin
            mdone <= 1'b1;
            mc    <= mult(mul_a, mul_b);
         end else begin
            mcnt <= mcnt + 1;
         end
      end
   end
   assign mul_done = mdone;
   assign mul_c    = mc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compares++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
      int bd = 0;
      @(negedge clk);
      in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
      while (!in_ready && bd < 500) begin
         @(negedge clk);
         bd++;
      end
      check("send_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic get_result(input string tag, input logic [N-1:0] ea, input logic [2:0] ec,
                             input logic es);
      int bd = 0;
      out_ready = 1'b1;
      while (!out_valid && bd < 500) begin
         @(negedge clk);
         bd++;
      end
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_acc"}, out_acc, ea);
      check({tag, "_count"}, out_count, ec);
      check({tag, "_sat"}, out_sat, es);
`ifdef MAC_TIMEOUT_EN
      check({tag, "_err"}, out_err, 1'b0);
`endif
      @(posedge clk);
      #1 out_ready = 1'b0;
      check({tag, "_drop"}, out_valid, 1'b0);
   endtask

   initial begin
      int runs;
      int bd;
      logic seen;
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_mul_rst", mul_rst, 1'b1);
      check("rst_mul_en", mul_en, 1'b0);
      check("rst_mul_a", mul_a, 32'd0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_acc", out_acc, 32'd0);
      check("rst_out_count", out_count, 3'd0);
      check("rst_out_sat", out_sat, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_mul_rst", mul_rst, 1'b0);

      // 1.5*2.0 + (-0.5)*1.0 = 2.5
      send(32'h00018000, 32'h00020000, 1'b0);
      send(32'h80008000, 32'h00010000, 1'b1);
      get_result("t1", 32'h00028000, 3'd2, 1'b0);

      // positive overflow saturates
      send(32'h40000000, 32'h00010000, 1'b0);
      send(32'h40000000, 32'h00010000, 1'b1);
      get_result("t2", 32'h7FFFFFFF, 3'd2, 1'b1);

      // exact cancellation gives +0
      send(32'h00010000, 32'h00010000, 1'b0);
      send(32'h80010000, 32'h00010000, 1'b1);
      get_result("t3", 32'h00000000, 3'd2, 1'b0);

      // vector closes at LEN terms without in_last
      repeat (4) send(32'h00010000, 32'h00010000, 1'b0);
      get_result("t4", 32'h00040000, 3'd4, 1'b0);
      send(32'h00010000, 32'h00010000, 1'b1);
      get_result("t4b", 32'h00010000, 3'd1, 1'b0);

      // output backpressure with a pending input
      send(32'h00010000, 32'h00030000, 1'b1);
      bd = 0;
      while (!out_valid && bd < 500) begin
         @(negedge clk);
         bd++;
      end
      in_valid = 1'b1; in_a = 32'h00020000; in_b = 32'h00020000; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t5_in_ready", in_ready, 1'b0);
         check("t5_valid", out_valid, 1'b1);
         check("t5_acc", out_acc, 32'h00030000);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("t5_drop", out_valid, 1'b0);
      check("t5_ready_back", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      get_result("t5b", 32'h00040000, 3'd1, 1'b0);

      // reset during the 3rd RUN cycle of the second term
      send(32'h00010000, 32'h00010000, 1'b0);
      send(32'h00020000, 32'h00010000, 1'b0);
      runs = 0;
      bd = 0;
      while (runs < 3 && bd < 500) begin
         @(negedge clk);
         if (mul_en) runs++;
         bd++;
      end
      check("t6_runs", runs, 3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t6_in_ready", in_ready, 1'b0);
      check("t6_mul_en", mul_en, 1'b0);
      check("t6_mul_a", mul_a, 32'd0);
      check("t6_mul_b", mul_b, 32'd0);
      check("t6_valid", out_valid, 1'b0);
      check("t6_acc", out_acc, 32'd0);
      check("t6_count", out_count, 3'd0);
      check("t6_sat", out_sat, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("t6_no_output", seen, 1'b0);
      send(32'h00030000, 32'h00010000, 1'b1);
      get_result("t6b", 32'h00030000, 3'd1, 1'b0);

`ifdef MAC_TIMEOUT_EN
      // stalled multiplier is aborted after 4*N RUN cycles
      stall = 1'b1;
      send(32'h00010000, 32'h00010000, 1'b1);
      runs = 0;
      bd = 0;
      while (!out_valid && bd < 1000) begin
         @(negedge clk);
         if (mul_en) runs++;
         bd++;
      end
      check("wd_runs", runs, 128);
      check("wd_valid", out_valid, 1'b1);
      check("wd_acc", out_acc, 32'd0);
      check("wd_err", out_err, 1'b1);
      check("wd_count", out_count, 3'd1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      check("wd_err_clr", out_err, 1'b0);
      stall = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
      $finish;
   end
endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Multi-cycle multiply-accumulate controller for sign-magnitude fixed-point operands (bit N-1 = sign, bits N-2:0 = magnitude, Q fractional bits).
- Accepts operand pairs over a valid/ready stream.
- Drives an external iterative multiplier through its rst/enable/done handshake and waits for each product.
- Accumulates products with saturation into a dot-product result.
- Emits one result per vector over a valid/ready output stream.
- Sits directly upstream of the sequential multiplier and consumes what it produces.

Parameters:
N, 32, total word width in bits (sign + magnitude).
Q, 16, fractional bits; carried only for consistency with the multiplier, not used in accumulator arithmetic.
LEN, 16, maximum number of terms per vector; a vector closes on in_last or on the LEN-th term.

Ports:
clk  in  1  clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand pair present.
in_ready  out  1  block can accept an operand pair.
in_a  in  N  operand A.
in_b  in  N  operand B.
in_last  in  1  this pair is the final term of the vector.
mul_rst  out  1  reset and load strobe to the multiplier.
mul_en  out  1  enable to the multiplier.
mul_a  out  N  operand A held to the multiplier.
mul_b  out  N  operand B held to the multiplier.
mul_done  in  1  multiplier finished.
mul_c  in  N  multiplier product.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_acc  out  N  accumulated result.
out_count  out  $clog2(LEN+1)  number of terms in the result.
out_sat  out  1  saturation occurred at least once in this vector.

Behaviour:
- Reset values:
  - State goes to IDLE.
  - in_ready=0 during rst.
  - mul_en=0, mul_a=0, mul_b=0.
  - out_valid=0, out_acc=0, out_count=0, out_sat=0.
  - Accumulator and term counter are cleared.
- mul_rst is asserted combinationally as rst OR (state==LOAD).
- Reset mid-operation discards the current term and the partial vector, with no output.
- FSM states: IDLE, LOAD, RUN, ACC, OUT.
- IDLE:
  - in_ready=1.
  - A transfer occurs when in_valid && in_ready. It captures in_a, in_b and in_last into registers and moves to LOAD.
- LOAD:
  - Lasts one cycle.
  - mul_rst=1, mul_en=0.
  - mul_a and mul_b present the captured operands and stay stable through RUN.
  - Next state is RUN.
- RUN:
  - mul_en=1.
  - mul_done is sampled every cycle. Because LOAD cleared the multiplier, any done seen here is fresh.
  - On mul_done=1, capture mul_c into the product register and move to ACC.
- ACC:
  - Lasts one cycle.
  - acc <= sat_add(acc, prod), and count <= count+1.
  - If last_reg=1 or count+1==LEN, move to OUT; otherwise return to IDLE.
  - in_ready is back to 1 in the cycle after ACC.
- OUT:
  - out_valid=1.
  - out_acc, out_count and out_sat are stable while out_ready=0.
  - On out_ready=1:
    - Clear acc, count and sat.
    - out_valid drops to 0 in the next cycle.
    - Return to IDLE.
  - in_ready=0 throughout OUT (backpressure).
- Throughput: one term per (k+3) cycles, where k = multiplier latency in RUN.
  - Transfer at cycle t, LOAD at t+1, RUN from t+2, ACC one cycle after done.
- sat_add (sign-magnitude):
  - A product of -0 (0x8000_0000 pattern, zero magnitude) is normalised to +0 before the add.
  - Equal signs: magnitudes are added in N bits. If the sum exceeds 2^(N-1)-1, clamp the magnitude to all-ones, keep the sign, and set sat.
  - Opposite signs: the larger magnitude minus the smaller. The result takes the sign of the larger operand. An exact tie gives +0.
  - The accumulator never holds -0.
- Simultaneous out_ready and in_valid in OUT: only the output transfer happens; the input waits because in_ready=0.

Optional Feature:
Macro MAC_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles in RUN.
  - If mul_done has not been seen after 4*N cycles, the term is aborted and its product is treated as +0.
  - The FSM proceeds to ACC as normal.
  - A sticky output port out_err (1 bit, reset 0, cleared on output transfer) is set for that vector.
- When undefined: RUN waits indefinitely, and neither out_err nor the watchdog exists.

Test Plan:
1. Pairs (0x00018000, 0x00020000) then (0x80008000, 0x00010000, last), with a model multiplier of latency 8 -> out_acc=0x00028000, out_count=2, out_sat=0.
2. (0x40000000, 0x00010000) twice, last on the second -> out_acc=0x7FFFFFFF, out_sat=1.
3. (0x00010000, 0x00010000) then (0x80010000, 0x00010000, last) -> out_acc=0x00000000 (not 0x80000000).
4. LEN=4, in_last never asserted, five pairs of 1.0*1.0 -> result after the 4th term: out_acc=0x00040000, out_count=4. The 5th term starts a new vector.
5. Hold out_ready=0 for 10 cycles during OUT, with in_valid=1 -> in_ready stays 0 and out_acc stays stable. Then raise out_ready -> one transfer, and in_ready=1 in the next cycle.
6. Assert rst in the 3rd RUN cycle -> all outputs are 0 in the next cycle and no out_valid follows. With MAC_TIMEOUT_EN and mul_done tied 0 -> ACC occurs after 128 RUN cycles, out_acc=0x00000000, out_err=1.
